otter_uart_tx_io: RTL and testbench
===================================

# otter_uart_tx_io

Memory-mapped UART transmitter peripheral that responds to the OTTER MCU's IOBUS. It is the responder end of the IOBUS interface that the MCU drives through IOBUS_ADDR, IOBUS_OUT and IOBUS_WR. Bytes stored by the MCU to a data address are queued in a small FIFO and serialised 8N1 onto TX. A status word is returned to the top-level IOBUS_IN read mux.

## Interface
Parameters:
- CLK_RATE, 50: clock frequency in MHz.
- BAUD, 115200: line rate. DIV = round(CLK_RATE*1_000_000/BAUD), which is 434 at defaults. DIV must be at least 2.
- TX_ADDR, 32'h1100_00C0: data register address. Write-only.
- STAT_ADDR, 32'h1100_00C4: status register address. Readable; writable for overflow clear.
- FIFO_DEPTH, 8: power of two, at least 2.

Ports:
- CLK  in  1  system clock. This is the only clock.
- RST  in  1  asynchronous, active-high reset.
- IOBUS_ADDR  in  32  MCU store/load address.
- IOBUS_OUT  in  32  MCU store data.
- IOBUS_WR  in  1  MCU store strobe, one cycle per store.
- IO_RDATA  out  32  status word. Valid only when IO_HIT=1, otherwise 0.
- IO_HIT  out  1  IOBUS_ADDR == STAT_ADDR. Used by the top-level IOBUS_IN mux.
- TX  out  1  serial line, idle high.

## Operation
- Push: on a rising edge where IOBUS_WR=1 and IOBUS_ADDR==TX_ADDR, IOBUS_OUT[7:0] is written into the FIFO. Bits [31:8] are ignored.
- Full-FIFO push: the byte is dropped and the sticky OVF flag is set.
- Clear: a write to STAT_ADDR with IOBUS_OUT[3]=1 clears OVF. All other bits of that write are ignored.
- If a push-to-full and an OVF clear occur on the same edge, the set wins.
- Status word (IO_RDATA, combinational from registered state):
  - [0] BUSY (state != IDLE)
  - [1] FULL
  - [2] EMPTY
  - [3] OVF
  - [7:4] COUNT, saturating at 15
  - [31:8] = 0
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If the FIFO is not empty, pop the head into shift register SR on this edge, clear the baud counter and bit index, and go to START.
  - START: TX=0 for DIV cycles, then go to DATA.
  - DATA: TX=SR[0] for DIV cycles, then shift SR right and increment the bit index. After bit index 7 completes, go to STOP. Bits go out LSB first.
  - STOP: TX=1 for DIV cycles, then go to IDLE.
- Baud counter: counts 0..DIV-1 and wraps. Its width is $clog2(DIV). It is held at 0 in IDLE.
- FIFO: circular pointers with one extra wrap bit each. FULL when the pointers differ only in the wrap bit. EMPTY when the pointers are equal.
- Simultaneous push and pop on the same edge:
  - When FULL, both are accepted and COUNT is unchanged.
  - When EMPTY, the pop is not performed and the push lands.
- TX is driven from a flop, so there are no glitches.

## Timing
- Reset values, applied asynchronously and immediately:
  - TX=1, state=IDLE, FIFO empty, OVF=0.
  - IO_RDATA reflects EMPTY=1 once IO_HIT=1.
- Reset asserted mid-frame: TX returns high immediately. The partial frame is abandoned and queued bytes are discarded.
- Latency: a push on edge E0 into an empty FIFO while IDLE gives TX=0 after edge E1.
- Frame length is 10*DIV cycles.
- Back-to-back bytes: exactly 1 idle cycle (TX=1, in IDLE) separates each STOP from the next START.
- IO_HIT and IO_RDATA are combinational from IOBUS_ADDR. They have zero-cycle latency so they satisfy the MCU's load path.

## Structure
- Package otter_io_pkg contains:
  - address constants TX_ADDR_DEF and STAT_ADDR_DEF
  - status bit indices ST_BUSY, ST_FULL, ST_EMPTY, ST_OVF, ST_CNT_LSB
  - typedef enum logic [1:0] uart_tx_state_t {IDLE, START, DATA, STOP}
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - inputs: push, pop, din
  - outputs: dout, full, empty, count
  - the same CLK/RST convention
  - reusable by a future uart_rx_io.
- The top level holds the address decode, the OVF flag, the FSM, the baud counter and SR.

## Test plan
Sim settings: CLK_RATE=1, BAUD=250000, which gives DIV=4.
- Single byte: write 0x55 to TX_ADDR.
  - TX low one cycle later.
  - Then 4 cycles each of 0,1,0,1,0,1,0,1,0,1 (start, data, stop); the data bits are 1,0,1,0,1,0,1,0.
  - BUSY drops after 40 cycles plus 1.
- Back-to-back: write 0xA5 and 0x3C on consecutive cycles.
  - Two frames with exactly one idle cycle between them.
  - COUNT reads 1 during the first frame.
- Overflow: write 10 bytes within 2 cycles of each other.
  - FULL=1, OVF=1, and 9 frames are sent. FIFO holds 8 plus 1 popped; the 10th byte is dropped.
  - A write of 0x8 to STAT_ADDR clears OVF.
- Push on a full FIFO on the exact edge the FSM pops: the byte is accepted, OVF stays 0, COUNT stays 8.
- Reset mid-DATA: assert RST at bit index 3.
  - TX=1 asynchronously, EMPTY=1, state IDLE.
  - After release, no TX activity until the next write.
- Address decode:
  - writes to TX_ADDR+4 and to unrelated addresses are ignored
  - IO_HIT=1 only at STAT_ADDR
  - IO_RDATA=0 elsewhere.

Source files
------------

// File: rtl/otter_io_pkg.sv
// ---------------------------------------------------------------------------
// otter_io_pkg
// Shared definitions for OTTER IOBUS peripherals:
//   - default register addresses of the UART transmitter
//   - bit positions inside the UART status word
//   - transmitter FSM state type
//   - helper that saturates a FIFO occupancy to the 4-bit COUNT field
// ---------------------------------------------------------------------------
package otter_io_pkg;

    localparam logic [31:0] TX_ADDR_DEF   = 32'h1100_00C0;
    localparam logic [31:0] STAT_ADDR_DEF = 32'h1100_00C4;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Occupancy above 15 cannot be represented in the 4-bit COUNT field,
    // so it is clamped rather than allowed to wrap.
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with circular pointers carrying one extra wrap bit.
//   CLK   in   clock
//   RST   in   asynchronous active-high reset (empties the FIFO)
//   push  in   write request; din is stored if there is room
//   pop   in   read request; head is discarded if not empty
//   din   in   write data
//   dout  out  head of the FIFO (combinational, valid when !empty)
//   full  out  DEPTH entries held
//   empty out  no entries held
//   count out  number of entries held (0..DEPTH)
// A push while full is accepted only when a pop happens on the same edge,
// and a pop while empty is ignored so a simultaneous push still lands.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers differing only in the wrap bit means the writer has lapped
    // the reader exactly once.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/otter_uart_tx_io.sv
// ---------------------------------------------------------------------------
// otter_uart_tx_io
// IOBUS responder that queues bytes stored by the OTTER MCU and sends them
// 8N1, LSB first, on TX.
//   CLK        in   system clock
//   RST        in   asynchronous active-high reset
//   IOBUS_ADDR in   MCU load/store address
//   IOBUS_OUT  in   MCU store data (byte in [7:0]; bit 3 clears OVF at STAT)
//   IOBUS_WR   in   one-cycle store strobe
//   IO_RDATA   out  status word when IO_HIT, else 0
//   IO_HIT     out  IOBUS_ADDR matches the status register
//   TX         out  registered serial line, idle high
// Status word: [0] BUSY, [1] FULL, [2] EMPTY, [3] OVF, [7:4] COUNT (sat).
// ---------------------------------------------------------------------------
module otter_uart_tx_io
    import otter_io_pkg::*;
#(
    parameter int          CLK_RATE   = 50,
    parameter int          BAUD       = 115200,
    parameter logic [31:0] TX_ADDR    = TX_ADDR_DEF,
    parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IO_RDATA,
    output logic        IO_HIT,
    output logic        TX
);

    localparam int DIV = (CLK_RATE * 1_000_000 + BAUD / 2) / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    uart_tx_state_t state;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     sr;
    logic           ovf;

    logic           tx_push;
    logic           stat_wr;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           ovf_set;
    logic           ovf_clr;
    logic [31:0]    status;
    logic           unused_bits;

    assign tx_push  = IOBUS_WR && (IOBUS_ADDR == TX_ADDR);
    assign stat_wr  = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR);
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    // A push into a full FIFO only loses data when no pop frees a slot on
    // the same edge.
    assign ovf_set  = tx_push && fifo_full && !fifo_pop;
    assign ovf_clr  = stat_wr && IOBUS_OUT[3];

    assign unused_bits = ^IOBUS_OUT[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (tx_push),
        .pop   (fifo_pop),
        .din   (IOBUS_OUT[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                     = '0;
        status[ST_BUSY]            = (state != IDLE);
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_OVF]             = ovf;
        status[ST_CNT_LSB +: 4]    = sat_count4(32'(fifo_count));
    end

    assign IO_HIT   = (IOBUS_ADDR == STAT_ADDR);
    assign IO_RDATA = IO_HIT ? status : 32'h0;

    // Set has priority so an overflow coincident with a clear is not lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // TX is loaded with the level of the bit period being entered, so the
    // line changes exactly on the edge where the state changes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sr       <= '0;
            TX       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    TX       <= 1'b1;
                    if (!fifo_empty) begin
                        sr      <= fifo_dout;
                        bit_idx <= '0;
                        state   <= START;
                        TX      <= 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        TX       <= sr[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        sr       <= {1'b0, sr[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            TX    <= 1'b1;
                        end else begin
                            TX    <= sr[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    TX <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_uart_tx_io.sv
// ---------------------------------------------------------------------------
// tb_otter_uart_tx_io
// Directed bench for the UART transmitter at CLK_RATE=1, BAUD=250000 (DIV=4).
// Bytes written to the data register are queued as expected frames; a
// line monitor rebuilds every frame from TX sample by sample and compares
// it against the head of that queue.
// ---------------------------------------------------------------------------
module tb_otter_uart_tx_io;

    localparam int          DIV = 4;
    localparam logic [31:0] TXA = 32'h1100_00C0;
    localparam logic [31:0] STA = 32'h1100_00C4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IOBUS_ADDR = 32'h0;
    logic [31:0] IOBUS_OUT = 32'h0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IO_RDATA;
    logic        IO_HIT;
    logic        TX;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbQueue[$];
    int         frameDone = 0;
    int         lastGap = 0;
    int         idleRun = 0;

    logic [63:0] monVec;
    int          monIdx = 0;
    bit          monInFrame = 1'b0;
    logic [7:0]  monExp;

    otter_uart_tx_io #(
        .CLK_RATE   (1),
        .BAUD       (250000),
        .TX_ADDR    (TXA),
        .STAT_ADDR  (STA),
        .FIFO_DEPTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IO_RDATA   (IO_RDATA),
        .IO_HIT     (IO_HIT),
        .TX         (TX)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One store cycle, started on a falling edge; returns on the next one.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic readStatus(output logic [31:0] v);
        IOBUS_ADDR = STA;
        #1;
        v = IO_RDATA;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n;
        n = 0;
        while (frameDone < target && n < budget) begin
            @(negedge CLK);
            #1;
            n++;
        end
        checkOutput("frames_done", 64'(frameDone), 64'(target));
    endtask

    // Expected line samples, one per clock: start, 8 data bits LSB first, stop.
    function automatic logic [63:0] frameOf(input logic [7:0] d);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 10 * DIV; i++) begin
            int b;
            b = i / DIV;
            if (b == 0)      f[i] = 1'b0;
            else if (b == 9) f[i] = 1'b1;
            else             f[i] = d[b-1];
        end
        return f;
    endfunction

    // Line monitor: a frame begins at the first low sample and is 10*DIV
    // samples long; reset abandons a frame in progress.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (RST) begin
                monInFrame = 1'b0;
                idleRun    = 0;
            end else if (!monInFrame) begin
                if (TX === 1'b0) begin
                    monInFrame = 1'b1;
                    monVec     = '0;
                    monIdx     = 1;
                    lastGap    = idleRun;
                    idleRun    = 0;
                end else begin
                    idleRun++;
                end
            end else begin
                monVec[monIdx] = TX;
                monIdx++;
                if (monIdx == 10 * DIV) begin
                    monInFrame = 1'b0;
                    checkOutput("frame_queued", 64'(sbQueue.size() != 0), 64'd1);
                    if (sbQueue.size() != 0) begin
                        monExp = sbQueue.pop_front();
                        checkOutput("frame_bits", monVec, frameOf(monExp));
                    end
                    frameDone++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        logic [31:0] st;
        logic [7:0]  b;
        int          lows;
        int          base;
        bit          found;

        // Reset state
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("reset_tx", 64'(TX), 64'd1);
        readStatus(st);
        checkOutput("reset_status", 64'(st), 64'h4);
        checkOutput("reset_hit", 64'(IO_HIT), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Single byte 0x55, upper store bits must be ignored
        $display("[TB] single byte");
        sbQueue.push_back(8'h55);
        applyStimulus(TXA, 32'hFFFF_FF55);
        checkOutput("single_tx_idle_e0", 64'(TX), 64'd1);
        readStatus(st);
        checkOutput("single_status_queued", 64'(st), 64'h10);
        @(negedge CLK);
        checkOutput("single_tx_start", 64'(TX), 64'd0);
        readStatus(st);
        checkOutput("single_status_busy", 64'(st), 64'h5);
        repeat (39) @(negedge CLK);
        readStatus(st);
        checkOutput("single_busy_at_40", 64'(st[0]), 64'd1);
        @(negedge CLK);
        readStatus(st);
        checkOutput("single_status_at_41", 64'(st), 64'h4);
        checkOutput("single_frame_count", 64'(frameDone), 64'd1);

        // Back-to-back bytes on consecutive cycles
        $display("[TB] back-to-back");
        repeat (3) @(negedge CLK);
        sbQueue.push_back(8'hA5);
        sbQueue.push_back(8'h3C);
        applyStimulus(TXA, 32'h0000_00A5);
        applyStimulus(TXA, 32'h0000_003C);
        repeat (5) @(negedge CLK);
        readStatus(st);
        checkOutput("b2b_status_count1", 64'(st), 64'h11);
        waitFrames(3, 200);
        checkOutput("b2b_idle_gap", 64'(lastGap), 64'd1);

        // Overflow: 10 stores in a row, the 10th is dropped
        $display("[TB] overflow");
        repeat (5) @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            b = 8'h10 + 8'(i);
            if (i < 9) sbQueue.push_back(b);
            applyStimulus(TXA, {24'h0, b});
        end
        readStatus(st);
        checkOutput("ovf_status_set", 64'(st), 64'h8B);
        applyStimulus(STA, 32'h0000_0008);
        readStatus(st);
        checkOutput("ovf_status_cleared", 64'(st), 64'h83);

        // Store on the same edge the FSM pops a full FIFO
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge CLK);
            readStatus(st);
            if (st[0] == 1'b0) found = 1'b1;
        end
        checkOutput("popedge_idle_seen", 64'(found), 64'd1);
        checkOutput("popedge_status_pre", 64'(st), 64'h82);
        sbQueue.push_back(8'hC3);
        IOBUS_ADDR = TXA;
        IOBUS_OUT  = 32'h0000_00C3;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
        readStatus(st);
        checkOutput("popedge_status_post", 64'(st), 64'h83);
        waitFrames(13, 600);
        repeat (3) @(negedge CLK);
        readStatus(st);
        checkOutput("ovf_drained_status", 64'(st), 64'h4);

        // Reset during data bit 3
        $display("[TB] reset mid-frame");
        sbQueue.push_back(8'hF0);
        applyStimulus(TXA, 32'h0000_00F0);
        repeat (18) @(negedge CLK);
        checkOutput("rst_mid_tx_low", 64'(TX), 64'd0);
        #2 RST = 1'b1;
        #1;
        checkOutput("rst_async_tx", 64'(TX), 64'd1);
        readStatus(st);
        checkOutput("rst_async_status", 64'(st), 64'h4);
        sbQueue.delete();
        base = frameDone;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge CLK);
            if (TX !== 1'b1) lows++;
        end
        checkOutput("rst_no_activity", 64'(lows), 64'd0);
        checkOutput("rst_no_frame", 64'(frameDone), 64'(base));

        // Address decode
        $display("[TB] address decode");
        base = frameDone;
        applyStimulus(TXA + 32'd4, 32'h0000_0077);
        applyStimulus(32'h1100_00C8, 32'h0000_005A);
        applyStimulus(32'h0000_00C0, 32'h0000_005A);
        lows = 0;
        repeat (50) begin
            @(negedge CLK);
            if (TX !== 1'b1) lows++;
        end
        checkOutput("decode_no_tx", 64'(lows), 64'd0);
        checkOutput("decode_no_frame", 64'(frameDone), 64'(base));
        readStatus(st);
        checkOutput("decode_status", 64'(st), 64'h4);
        checkOutput("decode_hit_stat", 64'(IO_HIT), 64'd1);
        IOBUS_ADDR = TXA;
        #1;
        checkOutput("decode_hit_tx", 64'(IO_HIT), 64'd0);
        checkOutput("decode_rdata_tx", 64'(IO_RDATA), 64'd0);
        IOBUS_ADDR = 32'h1100_00C8;
        #1;
        checkOutput("decode_hit_other", 64'(IO_HIT), 64'd0);
        checkOutput("decode_rdata_other", 64'(IO_RDATA), 64'd0);

        checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
